// File: rtl/alu_pkg.sv
// Shared ALU encodings for the result unloader.
// Opcodes match the ALU; dest and beat-state codes are local.
package alu_pkg;

  localparam logic [4:0] AND    = 5'b00101;
  localparam logic [4:0] OR     = 5'b00110;
  localparam logic [4:0] ADD    = 5'b00011;
  localparam logic [4:0] SUB    = 5'b00100;
  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;
  localparam logic [4:0] SHL    = 5'b01001;
  localparam logic [4:0] SHR    = 5'b00111;
  localparam logic [4:0] SHRA   = 5'b01000;
  localparam logic [4:0] ROL    = 5'b01011;
  localparam logic [4:0] ROR    = 5'b01010;
  localparam logic [4:0] NEG    = 5'b10001;
  localparam logic [4:0] NOT    = 5'b10010;

  localparam logic [1:0] DEST_Z  = 2'b00;
  localparam logic [1:0] DEST_LO = 2'b01;
  localparam logic [1:0] DEST_HI = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } beat_state_e;

  function automatic logic is_wide(input logic [4:0] op);
    return (op == MUL_OP) || (op == DIV_OP);
  endfunction

endpackage

// File: rtl/alu_result_unloader_result_fifo.sv
// Synchronous DEPTH x W result FIFO.
// Registered head on rdata; no push/pop bypass.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by overflow
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/alu_result_unloader.sv
// Returns 64-bit ALU results to the 32-bit bus as one
// or two beats (Z, or LO then HI) over valid/ready.
module alu_result_unloader
  import alu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int WORD_W = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_opcode,
  input  logic [2*WORD_W-1:0]   in_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic [1:0]            out_dest,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow
);

  localparam int EW = 2 * WORD_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  beat_state_e   state;
  beat_state_e   state_nx;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_pop;
  logic [EW-1:0] head;
  logic [EW-1:0] entry;
  logic          head_wide;
  logic          ovf_q;

  assign in_ready  = !full && !clear;
  assign push      = in_valid && in_ready;
  assign entry     = {is_wide(in_opcode), in_result};
  assign head_wide = head[EW-1];
  assign busy      = !empty;
  assign overflow  = ovf_q;

  // occupancy after a pop this cycle, counting a same-cycle push
  assign count_pop = count + CW'(push) - CW'(1);

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_dest  = DEST_Z;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        // a push this edge is the head next cycle
        if (push || !empty) begin
          state_nx = LOW;
        end
      end
      LOW: begin
        out_valid = 1'b1;
        out_data  = head[WORD_W-1:0];
        out_dest  = head_wide ? DEST_LO : DEST_Z;
        out_last  = !head_wide;
        if (out_ready) begin
          if (head_wide) begin
            state_nx = HIGH;
          end else begin
            pop      = 1'b1;
            state_nx = (count_pop != '0) ? LOW : IDLE;
          end
        end
      end
      HIGH: begin
        out_valid = 1'b1;
        out_data  = head[EW-2:WORD_W];
        out_dest  = DEST_HI;
        out_last  = 1'b1;
        if (out_ready) begin
          pop      = 1'b1;
          state_nx = (count_pop != '0) ? LOW : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_result_unloader.sv
// Bench for alu_result_unloader: result-queue model
// checked every cycle against the DUT outputs.
module tb_alu_result_unloader;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [63:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_dest;
  logic        out_last;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wide;
    logic [63:0] res;
  } ent_t;

  ent_t q[$];
  bit   half;
  bit   ovf_m;

  alu_result_unloader #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // {valid, data, dest, last, busy, overflow, in_ready}
  function automatic logic [38:0] exp_vec();
    logic        v;
    logic [31:0] d;
    logic [1:0]  dst;
    logic        l;
    v = q.size() > 0;
    d = '0;
    dst = 2'b00;
    l = 1'b0;
    if (v) begin
      if (!q[0].wide) begin
        d = q[0].res[31:0];
        l = 1'b1;
      end else if (!half) begin
        d = q[0].res[31:0];
        dst = 2'b01;
      end else begin
        d = q[0].res[63:32];
        dst = 2'b10;
        l = 1'b1;
      end
    end
    return {v, d, dst, l, v, ovf_m,
            (q.size() < DEPTH) && !clear};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {out_valid, out_data, out_dest, out_last,
            busy, overflow, in_ready};
  endfunction

  task automatic drive(bit v, logic [4:0] op,
                       logic [63:0] r, bit rdy, bit clr);
    in_valid  = v;
    in_opcode = op;
    in_result = r;
    out_ready = rdy;
    clear     = clr;
    #1;
  endtask

  // advance one edge and apply the result-queue rules
  task automatic tick();
    bit acc;
    bit hs;
    acc = in_valid && !clear && (q.size() < DEPTH);
    hs  = !clear && (q.size() > 0) && out_ready;
    @(posedge clock);
    if (clear) begin
      q.delete();
      half  = 0;
      ovf_m = 0;
    end else begin
      if (in_valid && !acc) ovf_m = 1;
      if (hs) begin
        if (q[0].wide && !half) begin
          half = 1;
        end else begin
          void'(q.pop_front());
          half = 0;
        end
      end
      if (acc) q.push_back('{
        wide: (in_opcode == 5'b01111) || (in_opcode == 5'b10000),
        res: in_result});
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 5'd0, 64'd0, 0, 1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    tick();
    tick();
    drive(0, 5'd0, 64'd0, 0, 0);
    checks++;
    if (dut_vec() !== {1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(),
               {1'b0, 32'd0, 2'b00, 4'b0001});
    end
  endtask

  task automatic test_single_add();
    drive(1, 5'b00011, 64'h7, 1, 0);
    tick();
    drive(0, 5'd0, 64'd0, 1, 0);
    checks++;
    if (dut_vec() !== {1'b1, 32'h7, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_beat: got %h", dut_vec());
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL add_idle: got %b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_mul();
    drive(1, 5'b01111, 64'h0000_0001_FFFF_FFFE, 1, 0);
    tick();
    drive(0, 5'd0, 64'd0, 1, 0);
    checks++;
    if ({out_valid, out_data, out_dest, out_last} !==
        {1'b1, 32'hFFFF_FFFE, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL mul_lo: got %h", dut_vec());
    end
    tick();
    checks++;
    if ({out_valid, out_data, out_dest, out_last} !==
        {1'b1, 32'h1, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL mul_hi: got %h", dut_vec());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_end: got %b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [34:0] want [3];
    want[0] = {32'h5, 2'b01, 1'b0};
    want[1] = {32'h2, 2'b10, 1'b1};
    want[2] = {32'hF, 2'b00, 1'b1};
    drive(1, 5'b10000, {32'd2, 32'd5}, 0, 0);
    tick();
    drive(1, 5'b00110, 64'h0F, 0, 0);
    tick();
    drive(1, 5'b00011, 64'h99, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: in_ready got %b want 0", in_ready);
    end
    tick();
    drive(0, 5'd0, 64'd0, 1, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_data, out_dest, out_last} !==
          {1'b1, want[i]}) begin
        errors++;
        $display("FAIL ovf_beat%0d: got %h want %h", i,
                 {out_data, out_dest, out_last}, want[i]);
      end
      tick();
    end
    checks++;
    if ({out_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drop: got %b want 01", {out_valid, overflow});
    end
  endtask

  task automatic test_stall();
    bit rdy = 0;
    for (int i = 0; i < 40; i++) begin
      drive(($urandom % 3) != 0, 5'b01111,
            {$urandom, $urandom}, rdy, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
      rdy = !rdy;
    end
  endtask

  task automatic test_clear_mid();
    drive(1, 5'b01111, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    tick();
    drive(1, 5'b00011, 64'h1234, 1, 0);
    tick();
    drive(0, 5'd0, 64'd0, 0, 0);
    checks++;
    if ({out_valid, out_dest, in_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL clr_setup: got %b want 1100",
               {out_valid, out_dest, in_ready});
    end
    drive(1, 5'b00011, 64'h55, 1, 1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_ready: got %b want 0", in_ready);
    end
    tick();
    drive(0, 5'd0, 64'd0, 1, 0);
    checks++;
    if (dut_vec() !== {1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clr_flush: got %h", dut_vec());
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL clr_no_hi: got %b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'b00011, {$urandom, $urandom}, 1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i > 0) begin
        checks++;
        if ({out_valid, in_ready} !== 2'b11) begin
          errors++;
          $display("FAIL b2b_flow_%0d: got %b want 11", i,
                   {out_valid, in_ready});
        end
      end
      tick();
    end
    drive(0, 5'd0, 64'd0, 1, 0);
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 3);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    half  = 0;
    ovf_m = 0;
    test_reset();
    test_single_add();
    test_mul();
    test_overflow();
    test_stall();
    test_clear_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
